// File: rtl/bcd_seg7_scan_driver_pkg.sv
// bcd_seg7_scan_driver_pkg
//   Shared definitions for the multiplexed 7-segment driver: scan FSM state
//   encoding, active-low glyph constants ({g,f,e,d,c,b,a}) and the BCD glyph
//   lookup used by the decoder.
package bcd_seg7_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    // Number of BCD digits carried by the packed input (ones/tens/hundreds).
    localparam int NUM_DIGITS = 3;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;  // non-BCD nibble: segment g only
    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Non-BCD codes map to a dash so a corrupt value can never read as a digit.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = SEG_DASH;
        case (nib)
            4'd0: g = SEG_0;
            4'd1: g = SEG_1;
            4'd2: g = SEG_2;
            4'd3: g = SEG_3;
            4'd4: g = SEG_4;
            4'd5: g = SEG_5;
            4'd6: g = SEG_6;
            4'd7: g = SEG_7;
            4'd8: g = SEG_8;
            4'd9: g = SEG_9;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD nibble -> active-low 7-segment glyph.
// Ports
//   nib    in  4  BCD nibble (10..15 decode to a dash)
//   glyph  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import bcd_seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = seg7_glyph(nib);
    end

endmodule

// File: rtl/bcd_seg7_scan_driver.sv
// bcd_seg7_scan_driver
//   Captures a 3-digit packed BCD value on a 1-cycle strobe and shows it on a
//   time-multiplexed common-anode 7-segment display. Each anode slot is lit
//   for SCAN_DIV cycles followed by BLANK_CYC cycles with all anodes off.
//   Slots 3..NUM_AN-1 are timed but never lit, so the refresh period is fixed.
//   Optional macro LEADING_ZERO_BLANK_EN: suppress leading zeros on the
//   hundreds/tens digits (ones digit always shown).
// Ports
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   bcd_in     in   12      {hundreds, tens, ones} BCD nibbles
//   bcd_valid  in   1       1-cycle strobe qualifying bcd_in
//   bcd_ack    out  1       pulse the cycle after a strobe is captured
//   an         out  NUM_AN  anode enables, active-low
//   seg        out  7       {g,f,e,d,c,b,a}, active-low
//   dp         out  1       decimal point, active-low, held off
module bcd_seg7_scan_driver
    import bcd_seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 64,
    parameter int NUM_AN    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       bcd_in,
    input  logic              bcd_valid,
    output logic              bcd_ack,
    output logic [NUM_AN-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    // One prescaler serves both phases; size it for the longer one so a
    // BLANK_CYC larger than SCAN_DIV still reaches its terminal count.
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int PW      = $clog2(CNT_MAX);
    localparam int IW      = (NUM_AN > 1) ? $clog2(NUM_AN) : 1;

    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_AN - 1);

    scan_state_t       state;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [11:0]       val_q;
    logic              ack_q;
    logic [6:0]        glyph_q;   // glyph frozen at slot entry
    logic              lit_q;     // slot entry decided this slot is lit
    logic [NUM_AN-1:0] an_q;
    logic [6:0]        seg_q;

    logic              blank_done;
    logic              enter_scan;
    logic [IW-1:0]     idx_nxt;
    logic [11:0]       src;
    logic [3:0]        nib_sel;
    logic              digit_on;
    logic [6:0]        glyph_nxt;

    // Slot contents are sampled only when a slot begins; a strobe landing on
    // that same edge wins so the newest value is shown without extra delay.
    always_comb begin
        src        = bcd_valid ? bcd_in : val_q;
        blank_done = (state == ST_BLANK) && (presc == BLANK_LAST);
        enter_scan = ((state == ST_IDLE) && bcd_valid) || blank_done;

        idx_nxt = idx;
        if (blank_done)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);

        nib_sel  = 4'h0;
        digit_on = 1'b0;
        if (int'(idx_nxt) < NUM_DIGITS) begin
            digit_on = 1'b1;
            case (int'(idx_nxt))
                0:       nib_sel = src[3:0];
                1:       nib_sel = src[7:4];
                default: nib_sel = src[11:8];
            endcase
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((int'(idx_nxt) == 2) && (src[11:8] == 4'h0))
            digit_on = 1'b0;
        if ((int'(idx_nxt) == 1) && (src[11:4] == 8'h00))
            digit_on = 1'b0;
`endif
    end

    bcd_to_seg7 u_dec (
        .nib   (nib_sel),
        .glyph (glyph_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            presc   <= '0;
            idx     <= '0;
            val_q   <= '0;
            ack_q   <= 1'b0;
            glyph_q <= SEG_DARK;
            lit_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_DARK;
        end else begin
            // Capture is independent of the scan timing.
            ack_q <= bcd_valid;
            if (bcd_valid)
                val_q <= bcd_in;

            case (state)
                ST_IDLE: begin
                    if (bcd_valid) begin
                        state <= ST_SCAN;
                        presc <= '0;
                    end
                end
                ST_SCAN: begin
                    if (presc == SCAN_LAST) begin
                        state <= ST_BLANK;
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state <= ST_SCAN;
                        presc <= '0;
                        idx   <= idx_nxt;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    presc <= '0;
                end
            endcase

            if (enter_scan) begin
                glyph_q <= glyph_nxt;
                lit_q   <= digit_on;
            end

            // Pin registers follow the current state, one cycle behind it.
            an_q  <= '1;
            seg_q <= SEG_DARK;
            if ((state == ST_SCAN) && lit_q) begin
                an_q  <= ~(NUM_AN'(1) << idx);
                seg_q <= glyph_q;
            end
        end
    end

    assign bcd_ack = ack_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
module tb_bcd_seg7_scan_driver;

    localparam int S      = 8;
    localparam int B      = 2;
    localparam int N      = 4;
    localparam int SLOT   = S + B;
    localparam int PERIOD = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        bcd_valid = 1'b0;
    logic        bcd_ack;
    logic [N-1:0] an;
    logic [6:0]  seg;
    logic        dp;

    bcd_seg7_scan_driver #(.SCAN_DIV(S), .BLANK_CYC(B), .NUM_AN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ack   (bcd_ack),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    localparam logic [6:0] GLYPH [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] glyph_of(int d);
        if (d > 9) return 7'h3F;
        return GLYPH[d];
    endfunction

    function automatic bit slot_on(logic [11:0] v, int slot);
        if (slot > 2) return 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2 && v[11:8] == 4'h0) return 0;
        if (slot == 1 && v[11:4] == 8'h00) return 0;
`endif
        return 1;
    endfunction

    // Reference model: after the first capture edge e0, the display runs on a
    // fixed timeline. Slot k begins at edge e0 + k*SLOT, shows the newest value
    // captured by then, and is visible on the pins for S cycles starting one
    // edge later, followed by B dark cycles.
    initial begin
        longint      edge_n = 0;
        longint      e0 = 0;
        longint      rel;
        longint      r;
        bit          started = 0;
        logic [11:0] cur = 12'h000;
        logic [11:0] latched = 12'h000;
        exp_t        e;
        int          slot;
        forever begin
            @(posedge clk);
            e.an  = '1;
            e.seg = 7'h7F;
            e.ack = 1'b0;
            if (!rst_n) begin
                started = 0;
                cur     = 12'h000;
            end else begin
                if (bcd_valid) begin
                    cur = bcd_in;
                    if (!started) begin
                        started = 1;
                        e0      = edge_n;
                    end
                end
                e.ack = bcd_valid;
                if (started) begin
                    rel = edge_n - e0;
                    if (rel % SLOT == 0) latched = cur;
                    r = rel - 1;
                    if (r >= 0 && (r % SLOT) < S) begin
                        slot = int'((r / SLOT) % N);
                        if (slot_on(latched, slot)) begin
                            e.an  = ~(N'(1) << slot);
                            e.seg = glyph_of(int'((latched >> (4 * slot)) & 12'hF));
                        end
                    end
                end
            end
            exp_q.push_back(e);
            edge_n++;
        end
    end

    // Monitor: the pins present a new value every cycle; compare away from
    // the active edge.
    initial begin
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (!done) begin
                cyc++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL queue_empty cyc=%0d: no expected entry available", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (an !== e.an) begin
                        n_bad++;
                        $display("FAIL an cyc=%0d: got %h want %h", cyc, an, e.an);
                    end
                    n_cmp++;
                    if (seg !== e.seg) begin
                        n_bad++;
                        $display("FAIL seg cyc=%0d: got %h want %h", cyc, seg, e.seg);
                    end
                    n_cmp++;
                    if (bcd_ack !== e.ack) begin
                        n_bad++;
                        $display("FAIL bcd_ack cyc=%0d: got %b want %b", cyc, bcd_ack, e.ack);
                    end
                    n_cmp++;
                    if (dp !== 1'b1) begin
                        n_bad++;
                        $display("FAIL dp cyc=%0d: got %b want 1", cyc, dp);
                    end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(logic [11:0] v);
        @(negedge clk);
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        bcd_in    = 12'($urandom);
    endtask

    // Assert reset between edges and check the pins go dark with no clock.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (an !== '1 || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL async_reset: got an=%h seg=%h want an=f seg=7f", an, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(100);                       // idle: dark, no ack

        strobe(12'h123);
        tick(2 * PERIOD);
        strobe(12'h9A5);                 // invalid tens nibble -> dash
        tick(2 * PERIOD);

        async_reset();
        strobe(12'h456);
        tick(13);                        // lands inside digit 1's lit window
        strobe(12'h789);
        tick(2 * PERIOD);

        strobe(12'h321);
        tick(4);
        async_reset();                   // mid-scan reset
        tick(60);                        // stays dark until a new strobe

        strobe(12'h007);
        tick(PERIOD + 5);
        strobe(12'h000);
        tick(2 * PERIOD);

        repeat (200) begin
            strobe(12'($urandom_range(0, 4095)));
            tick($urandom_range(0, 40));
            if ($urandom_range(0, 19) == 0) async_reset();
        end
        tick(2 * PERIOD);

        done = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
